multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle control unit.
- Sequences each RV32I instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared instruction/data memory port with a ready handshake, so it works with wait-stated memory and the UART peripheral.
- Generalised in data width (branch comparator) and bounded memory-wait timeout.
- Sits between datapath (IR, PC, register file, ALU) and memory/UART bus.

Parameters:
- XLEN, 32, width of rf_out1/rf_out2 and the branch comparator.
- MAX_WAIT, 255, max cycles mem_req may stay unanswered before bus error; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instr  in  32  current IR contents (valid from DECODE onward)
- rf_out1  in  XLEN  rs1 value
- rf_out2  in  XLEN  rs2 value
- mem_ready  in  1  memory/peripheral completes the current request this cycle
- mem_req  out  1  memory access request
- addr_src  out  1  0 = PC address, 1 = ALU result
- mem_write  out  2  00 none, 01 byte, 10 half, 11 word
- read_mode  out  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ir_write  out  1  load IR from memory data
- pc_write  out  1  update PC
- pc_src  out  1  0 = PC+4, 1 = ALU target
- reg_write  out  1  register-file write enable
- result_src  out  2  00 ALU, 01 memory data, 10 PC+4
- imm_src  out  3  000 SEX12, 001 UEX12, 010 B, 011 J, 100 U, 101 S
- alu_src  out  2  bit0 = PC as operand A; bit1 = immediate as operand B
- alu_control  out  4  {funct3, alt} for OP/OP-IMM, else 0000 (ADD)
- state  out  3  current state: 0 FETCH, 1 DECODE, 2 EXECUTE, 3 MEMORY, 4 WRITEBACK, 7 HALT
- instr_retired  out  1  one-cycle pulse when an instruction completes
- bus_error  out  1  sticky; set on wait timeout

Behaviour:
- Reset: synchronous, active-high. state ← FETCH, wait counter ← 0, bus_error ← 0. All outputs are 0 in the reset cycle. A reset mid-access drops mem_req in the same cycle and abandons the access.
- Outputs: decoded combinationally from state and instr (Moore+instr). Unlisted outputs are 0 in each state.
- FETCH:
  - mem_req=1, addr_src=0.
  - On mem_ready: ir_write=1 → DECODE. Otherwise stay.
- DECODE: one cycle, no side effects → EXECUTE.
- EXECUTE (ALU inputs per opcode):
  - BRANCH:
    - Compare rf_out1/rf_out2: signed for BLT/BGE, unsigned for BLTU/BGEU, equality for BEQ/BNE.
    - alu_src=11 computes PC+imm_B.
    - pc_write=1, pc_src=taken, instr_retired=1 → FETCH.
  - LOAD/STORE: alu_src=10 (address) → MEMORY.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR → WRITEBACK.
  - Unknown opcode: NOP. pc_write=1, pc_src=0, instr_retired=1 → FETCH.
- MEMORY:
  - mem_req=1, addr_src=1.
  - Store: mem_write per funct3 (SB/SH/SW). On mem_ready: pc_write=1, instr_retired=1 → FETCH.
  - Load: read_mode per funct3. On mem_ready → WRITEBACK.
- WRITEBACK:
  - reg_write=1 unless instr[11:7]=0.
  - result_src: load=01, JAL/JALR=10, else 00.
  - pc_write=1, pc_src=1 for JAL/JALR, else 0.
  - instr_retired=1 → FETCH.
- Operand/immediate selection is held stable through WRITEBACK.
- alu_control:
  - OP: {funct3, funct7==0100000}.
  - OP-IMM: {funct3, funct3==101 & instr[30]}. ADDI with negative immediate must not yield SUB.
- imm_src: SLTIU → UEX12.
- Timeout:
  - Wait counter increments each FETCH/MEMORY cycle with mem_req=1 and !mem_ready; clears on mem_ready or state change.
  - When MAX_WAIT≠0 and counter reaches MAX_WAIT: bus_error ← 1, state ← HALT.
  - mem_ready in the same cycle as counter reaching MAX_WAIT wins (access completes, no error).
- HALT: all strobes 0. Exit only by reset.

Optional Feature:
- Macro MCTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal_instr (1 bit, sticky, cleared by reset).
  - Unknown opcode, or undefined funct3/funct7 for BRANCH/LOAD/STORE/OP/OP-IMM, detected in DECODE sets illegal_instr → HALT.
  - No pc_write, no retire.
- Undefined: port absent; such instructions execute as NOP (PC+4, retired).

Decomposition:
- Shared package mctrl_pkg:
  - opcode constants.
  - funct3 constants (branch/load/store/ALU).
  - state encoding.
  - imm_src, result_src, mem_write, read_mode encodings.
- One sub-module, branch_cmp (parametrised XLEN; inputs a, b, funct3; output taken), reusable by pipelined variants.

Test Plan:
- reset 3 cycles, then mem_ready=1 always; fetch ADDI x1,x0,-1 (0xFFF00093) → FETCH→DECODE→EXECUTE→WRITEBACK, alu_control=0000, reg_write=1 in cycle 4, instr_retired pulse, back to FETCH.
- BNE with rf_out1=5, rf_out2=5 → pc_write=1, pc_src=0 in EXECUTE. BLTU with rf_out1=0x1, rf_out2=0xFFFFFFFF → pc_src=1. BLT with same values → pc_src=0.
- SH with mem_ready delayed 4 cycles → mem_req held 5 cycles in MEMORY, mem_write=10, addr_src=1, pc_write only in the ready cycle.
- LBU x0 → read_mode=100, result_src=01, reg_write=0 in WRITEBACK (rd=0).
- MAX_WAIT=8, mem_ready never asserted in FETCH → bus_error=1 and state=7 after 8 wait cycles; stays until reset; reset returns to FETCH with bus_error=0.
- Opcode 0x7F with MCTRL_ILLEGAL_TRAP_EN → illegal_instr=1, HALT, no retire. Without the macro → PC+4 and instr_retired=1.

Source files
------------

// File: rtl/mctrl_pkg.sv
// rtl/mctrl_pkg.sv - shared opcode, funct3, state and control-field encodings for the multicycle controller
package mctrl_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_SR   = 3'b101;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        IMM_SEX12 = 3'd0,
        IMM_UEX12 = 3'd1,
        IMM_B     = 3'd2,
        IMM_J     = 3'd3,
        IMM_U     = 3'd4,
        IMM_S     = 3'd5
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2
    } result_src_t;

    typedef enum logic [1:0] {
        MW_NONE = 2'd0,
        MW_BYTE = 2'd1,
        MW_HALF = 2'd2,
        MW_WORD = 2'd3
    } mem_write_t;

    typedef enum logic [2:0] {
        RM_LB  = 3'd0,
        RM_LH  = 3'd1,
        RM_LW  = 3'd2,
        RM_LBU = 3'd4,
        RM_LHU = 3'd5
    } read_mode_t;

    // Flags opcodes outside RV32I's computational/memory subset and undefined funct3/funct7 combinations.
    function automatic logic is_illegal(input logic [31:0] ins);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       bad;
        f3  = ins[14:12];
        f7  = ins[31:25];
        bad = 1'b0;
        case (ins[6:0])
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: bad = 1'b0;
            OP_BRANCH: bad = (f3 == 3'b010) || (f3 == 3'b011);
            OP_LOAD:   bad = !(f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
            OP_STORE:  bad = !(f3 inside {F3_SB, F3_SH, F3_SW});
            OP_OP:     bad = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == F3_ADD) || (f3 == F3_SR))));
            OP_IMM:    bad = ((f3 == F3_SLL) && (f7 != 7'h00)) ||
                             ((f3 == F3_SR) && (f7 != 7'h00) && (f7 != 7'h20));
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/multicycle_controller_branch_cmp.sv
// rtl/multicycle_controller_branch_cmp.sv - XLEN-wide RV32I branch condition evaluator
module branch_cmp
    import mctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (a == b);
            F3_BNE:  taken = (a != b);
            F3_BLT:  taken = ($signed(a) < $signed(b));
            F3_BGE:  taken = ($signed(a) >= $signed(b));
            F3_BLTU: taken = (a < b);
            F3_BGEU: taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - RV32I multicycle control FSM with memory-wait timeout; MCTRL_ILLEGAL_TRAP_EN adds illegal-instruction halt
module multicycle_controller
    import mctrl_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rf_out1,
    input  logic [XLEN-1:0] rf_out2,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            addr_src,
    output logic [1:0]      mem_write,
    output logic [2:0]      read_mode,
    output logic            ir_write,
    output logic            pc_write,
    output logic            pc_src,
    output logic            reg_write,
    output logic [1:0]      result_src,
    output logic [2:0]      imm_src,
    output logic [1:0]      alu_src,
    output logic [3:0]      alu_control,
    output logic [2:0]      state,
    output logic            instr_retired,
    output logic            bus_error
`ifdef MCTRL_ILLEGAL_TRAP_EN
    ,
    output logic            illegal_instr
`endif
);

    localparam int            CW        = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = (MAX_WAIT == 0) ? '0 : CW'(MAX_WAIT - 1);

    state_t        st, st_nxt;
    logic [CW-1:0] wait_cnt;
    logic          bus_err_q;
    logic          stall, timeout, taken;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          is_store, is_jump;
    logic          unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign is_store      = (opcode == OP_STORE);
    assign is_jump       = (opcode == OP_JAL) || (opcode == OP_JALR);
    assign unused_fields = ^instr[24:15];

    // The timeout fires on the cycle that would make the wait count reach MAX_WAIT.
    assign stall   = ((st == S_FETCH) || (st == S_MEMORY)) && !mem_ready;
    assign timeout = (MAX_WAIT != 0) && stall && (wait_cnt == WAIT_LAST);

    branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
        .a      (rf_out1),
        .b      (rf_out2),
        .funct3 (funct3),
        .taken  (taken)
    );

    always_comb begin
        st_nxt        = st;
        mem_req       = 1'b0;
        addr_src      = 1'b0;
        mem_write     = MW_NONE;
        read_mode     = RM_LB;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        reg_write     = 1'b0;
        result_src    = RES_ALU;
        imm_src       = IMM_SEX12;
        alu_src       = 2'b00;
        alu_control   = 4'b0000;
        instr_retired = 1'b0;

        if (!reset) begin
            // Operand/immediate selection stays put from EXECUTE until the instruction retires.
            if ((st == S_EXECUTE) || (st == S_MEMORY) || (st == S_WRITEBACK)) begin
                case (opcode)
                    OP_OP:     alu_control = {funct3, instr[31:25] == 7'b0100000};
                    OP_IMM: begin
                        alu_src     = 2'b10;
                        imm_src     = (funct3 == F3_SLTU) ? IMM_UEX12 : IMM_SEX12;
                        alu_control = {funct3, (funct3 == F3_SR) && instr[30]};
                    end
                    OP_LOAD:   alu_src = 2'b10;
                    OP_STORE:  begin alu_src = 2'b10; imm_src = IMM_S; end
                    OP_BRANCH: begin alu_src = 2'b11; imm_src = IMM_B; end
                    OP_LUI:    begin alu_src = 2'b10; imm_src = IMM_U; end
                    OP_AUIPC:  begin alu_src = 2'b11; imm_src = IMM_U; end
                    OP_JAL:    begin alu_src = 2'b11; imm_src = IMM_J; end
                    OP_JALR:   alu_src = 2'b10;
                    default:   alu_src = 2'b00;
                endcase
            end

            case (st)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        st_nxt   = S_DECODE;
                    end else if (timeout) begin
                        st_nxt = S_HALT;
                    end
                end
                S_DECODE: begin
                    st_nxt = S_EXECUTE;
`ifdef MCTRL_ILLEGAL_TRAP_EN
                    if (is_illegal(instr)) st_nxt = S_HALT;
`endif
                end
                S_EXECUTE: begin
                    case (opcode)
                        OP_BRANCH: begin
                            pc_write      = 1'b1;
                            pc_src        = taken;
                            instr_retired = 1'b1;
                            st_nxt        = S_FETCH;
                        end
                        OP_LOAD, OP_STORE: st_nxt = S_MEMORY;
                        OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: st_nxt = S_WRITEBACK;
                        default: begin
                            pc_write      = 1'b1;
                            instr_retired = 1'b1;
                            st_nxt        = S_FETCH;
                        end
                    endcase
                end
                S_MEMORY: begin
                    mem_req  = 1'b1;
                    addr_src = 1'b1;
                    if (is_store) begin
                        case (funct3)
                            F3_SB:   mem_write = MW_BYTE;
                            F3_SH:   mem_write = MW_HALF;
                            F3_SW:   mem_write = MW_WORD;
                            default: mem_write = MW_NONE;
                        endcase
                    end else begin
                        case (funct3)
                            F3_LB:   read_mode = RM_LB;
                            F3_LH:   read_mode = RM_LH;
                            F3_LBU:  read_mode = RM_LBU;
                            F3_LHU:  read_mode = RM_LHU;
                            default: read_mode = RM_LW;
                        endcase
                    end
                    if (mem_ready) begin
                        if (is_store) begin
                            pc_write      = 1'b1;
                            instr_retired = 1'b1;
                            st_nxt        = S_FETCH;
                        end else begin
                            st_nxt = S_WRITEBACK;
                        end
                    end else if (timeout) begin
                        st_nxt = S_HALT;
                    end
                end
                S_WRITEBACK: begin
                    reg_write     = (instr[11:7] != 5'd0);
                    result_src    = (opcode == OP_LOAD) ? RES_MEM : (is_jump ? RES_PC4 : RES_ALU);
                    pc_write      = 1'b1;
                    pc_src        = is_jump;
                    instr_retired = 1'b1;
                    st_nxt        = S_FETCH;
                end
                S_HALT:  st_nxt = S_HALT;
                default: st_nxt = S_HALT;
            endcase
        end
    end

    assign state     = reset ? S_FETCH : st;
    assign bus_error = reset ? 1'b0 : bus_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            st        <= S_FETCH;
            wait_cnt  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            st       <= st_nxt;
            wait_cnt <= (stall && !timeout) ? wait_cnt + 1'b1 : '0;
            if (timeout) bus_err_q <= 1'b1;
        end
    end

`ifdef MCTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if ((st == S_DECODE) && is_illegal(instr)) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_instr = reset ? 1'b0 : illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized self-checking bench for multicycle_controller against a per-instruction cycle model
module tb_multicycle_controller;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 8;
    localparam int HN       = 8192;

    typedef struct packed {
        logic       mem_req;
        logic       addr_src;
        logic [1:0] mem_write;
        logic [2:0] read_mode;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic [1:0] result_src;
        logic [2:0] imm_src;
        logic [1:0] alu_src;
        logic [3:0] alu_control;
        logic [2:0] state;
        logic       instr_retired;
        logic       bus_error;
    } out_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [31:0]     instr;
    logic [XLEN-1:0] rf_out1, rf_out2;
    logic            mem_ready;
    logic            mem_req, addr_src, ir_write, pc_write, pc_src, reg_write, instr_retired, bus_error;
    logic [1:0]      mem_write, result_src, alu_src;
    logic [2:0]      read_mode, imm_src, state;
    logic [3:0]      alu_control;
`ifdef MCTRL_ILLEGAL_TRAP_EN
    logic            illegal_instr;
`endif

    out_t act, exp_o;
    out_t hist [0:HN-1];
    logic chk_en  = 1'b0;
    logic exp_ill = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc_n   = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .instr         (instr),
        .rf_out1       (rf_out1),
        .rf_out2       (rf_out2),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .addr_src      (addr_src),
        .mem_write     (mem_write),
        .read_mode     (read_mode),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .result_src    (result_src),
        .imm_src       (imm_src),
        .alu_src       (alu_src),
        .alu_control   (alu_control),
        .state         (state),
        .instr_retired (instr_retired),
        .bus_error     (bus_error)
`ifdef MCTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_instr (illegal_instr)
`endif
    );

    assign act = {mem_req, addr_src, mem_write, read_mode, ir_write, pc_write, pc_src, reg_write,
                  result_src, imm_src, alu_src, alu_control, state, instr_retired, bus_error};

    // Single compare point, mid-cycle, against whatever the driver declared for this cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                hist[cyc_n % HN] = act;
                checks++;
                if (act !== exp_o) begin
                    errors++;
                    $display("FAIL cycle %0d outputs act=%h exp=%h (state act=%0d exp=%0d instr=%h)",
                             cyc_n, act, exp_o, act.state, exp_o.state, instr);
                end
`ifdef MCTRL_ILLEGAL_TRAP_EN
                checks++;
                if (illegal_instr !== exp_ill) begin
                    errors++;
                    $display("FAIL cycle %0d illegal_instr act=%b exp=%b", cyc_n, illegal_instr, exp_ill);
                end
`endif
                cyc_n++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic out_t hst(input int i);
        return hist[i % HN];
    endfunction

    task automatic lit(input string name, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", name, a, e);
        end
    endtask

    task automatic cyc(input out_t e, input logic rdy);
        mem_ready = rdy;
        exp_o     = e;
        chk_en    = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Operand/immediate selection implied by the opcode class.
    function automatic out_t sel(input logic [31:0] ins);
        out_t       e;
        logic [2:0] f3;
        e  = '0;
        f3 = ins[14:12];
        case (ins[6:0])
            7'h33: e.alu_control = {f3, ins[31:25] == 7'h20};
            7'h13: begin
                e.alu_src     = 2'b10;
                e.imm_src     = (f3 == 3'd3) ? 3'd1 : 3'd0;
                e.alu_control = {f3, (f3 == 3'd5) && ins[30]};
            end
            7'h03: e.alu_src = 2'b10;
            7'h23: begin e.alu_src = 2'b10; e.imm_src = 3'd5; end
            7'h63: begin e.alu_src = 2'b11; e.imm_src = 3'd2; end
            7'h37: begin e.alu_src = 2'b10; e.imm_src = 3'd4; end
            7'h17: begin e.alu_src = 2'b11; e.imm_src = 3'd4; end
            7'h6F: begin e.alu_src = 2'b11; e.imm_src = 3'd3; end
            7'h67: e.alu_src = 2'b10;
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Expands one instruction into its expected per-cycle outputs and drives it through the DUT.
    task automatic run_instr(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                             input int fw, input int mw, output int s);
        out_t       e, sl;
        logic [6:0] op;
        logic [2:0] f3;
        logic       jmp;
        op      = ins[6:0];
        f3      = ins[14:12];
        jmp     = (op == 7'h6F) || (op == 7'h67);
        instr   = ins;
        rf_out1 = a;
        rf_out2 = b;
        s       = cyc_n;
        e = '0; e.mem_req = 1'b1;
        repeat (fw) cyc(e, 1'b0);
        e.ir_write = 1'b1;
        cyc(e, 1'b1);
        e = '0; e.state = 3'd1;
        cyc(e, rb());
        sl = sel(ins);
        e = sl; e.state = 3'd2;
        if (op == 7'h63) begin
            e.pc_write = 1'b1; e.pc_src = br_taken(f3, a, b); e.instr_retired = 1'b1;
            cyc(e, rb());
            return;
        end
        if (!(op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67})) begin
            e.pc_write = 1'b1; e.instr_retired = 1'b1;
            cyc(e, rb());
            return;
        end
        cyc(e, rb());
        if ((op == 7'h03) || (op == 7'h23)) begin
            e = sl; e.state = 3'd3; e.mem_req = 1'b1; e.addr_src = 1'b1;
            if (op == 7'h23) e.mem_write = 2'(f3 + 3'd1);
            else             e.read_mode = f3;
            repeat (mw) cyc(e, 1'b0);
            if (op == 7'h23) begin
                e.pc_write = 1'b1; e.instr_retired = 1'b1;
                cyc(e, 1'b1);
                return;
            end
            cyc(e, 1'b1);
        end
        e = sl; e.state = 3'd4;
        e.reg_write     = (ins[11:7] != 5'd0);
        e.result_src    = (op == 7'h03) ? 2'd1 : (jmp ? 2'd2 : 2'd0);
        e.pc_write      = 1'b1;
        e.pc_src        = jmp;
        e.instr_retired = 1'b1;
        cyc(e, rb());
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          k, j;
`ifdef MCTRL_ILLEGAL_TRAP_EN
        k = $urandom_range(0, 8);
`else
        k = $urandom_range(0, 9);
`endif
        r = $urandom;
        case (k)
            0: begin r[6:0] = 7'h33; r[31:25] = rb() ? 7'h20 : 7'h00; end
            1: begin
                r[6:0] = 7'h13;
                if (r[14:12] == 3'd1) r[31:25] = 7'h00;
                if (r[14:12] == 3'd5) r[31:25] = rb() ? 7'h20 : 7'h00;
            end
            2: begin r[6:0] = 7'h03; j = $urandom_range(0, 4); r[14:12] = (j < 3) ? 3'(j) : 3'(j + 1); end
            3: begin r[6:0] = 7'h23; r[14:12] = 3'($urandom_range(0, 2)); end
            4: begin r[6:0] = 7'h63; j = $urandom_range(0, 5); r[14:12] = (j < 2) ? 3'(j) : 3'(j + 2); end
            5: r[6:0] = 7'h37;
            6: r[6:0] = 7'h17;
            7: r[6:0] = 7'h6F;
            8: r[6:0] = 7'h67;
            default: begin
                j = $urandom_range(0, 3);
                r[6:0] = (j == 0) ? 7'h7F : (j == 1) ? 7'h0F : (j == 2) ? 7'h73 : 7'h00;
            end
        endcase
        return r;
    endfunction

    initial begin
        out_t        e;
        int          s, n, fw, mw;
        logic [31:0] a, b;

        reset = 1'b1; mem_ready = 1'b0; instr = $urandom; rf_out1 = '0; rf_out2 = '0;
        #1;
        repeat (3) cyc('0, rb());
        reset = 1'b0;

        run_instr(32'hFFF00093, 32'd0, 32'd0, 0, 0, s);
        lit("addi_fetch_irwrite", int'(hst(s).ir_write), 1);
        lit("addi_exec_state", int'(hst(s + 2).state), 2);
        lit("addi_exec_noretire", int'(hst(s + 2).instr_retired), 0);
        lit("addi_wb_state", int'(hst(s + 3).state), 4);
        lit("addi_wb_aluctl", int'(hst(s + 3).alu_control), 0);
        lit("addi_wb_regwrite", int'(hst(s + 3).reg_write), 1);
        lit("addi_wb_retire", int'(hst(s + 3).instr_retired), 1);

        run_instr(32'h00209063, 32'd5, 32'd5, 0, 0, s);
        lit("bne_eq_pcwrite", int'(hst(s + 2).pc_write), 1);
        lit("bne_eq_pcsrc", int'(hst(s + 2).pc_src), 0);
        run_instr(32'h0020E063, 32'h1, 32'hFFFF_FFFF, 0, 0, s);
        lit("bltu_pcsrc", int'(hst(s + 2).pc_src), 1);
        run_instr(32'h0020C063, 32'h1, 32'hFFFF_FFFF, 0, 0, s);
        lit("blt_pcsrc", int'(hst(s + 2).pc_src), 0);

        run_instr(32'h00209023, 32'd0, 32'd0, 0, 4, s);
        n = 0;
        for (int k = 3; k <= 7; k++) n += int'(hst(s + k).mem_req);
        lit("sh_memreq_cycles", n, 5);
        n = 0;
        for (int k = 3; k <= 7; k++) n += int'(hst(s + k).pc_write);
        lit("sh_pcwrite_count", n, 1);
        lit("sh_pcwrite_ready", int'(hst(s + 7).pc_write), 1);
        lit("sh_memwrite", int'(hst(s + 5).mem_write), 2);
        lit("sh_addrsrc", int'(hst(s + 5).addr_src), 1);

        run_instr(32'h0000C003, 32'd0, 32'd0, 0, 0, s);
        lit("lbu_readmode", int'(hst(s + 3).read_mode), 4);
        lit("lbu_resultsrc", int'(hst(s + 4).result_src), 1);
        lit("lbu_x0_regwrite", int'(hst(s + 4).reg_write), 0);

        run_instr(32'h0000A083, 32'd0, 32'd0, 7, 7, s);
        lit("lw_wait7_fetch_done", int'(hst(s + 7).ir_write), 1);
        lit("lw_wait7_no_error", int'(hst(s + 16).bus_error), 0);

        for (int i = 0; i < 200; i++) begin
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
            fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0;
            mw = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : 0;
            run_instr(rand_instr(), a, b, fw, mw, s);
        end

`ifdef MCTRL_ILLEGAL_TRAP_EN
        instr = 32'h0000007F;
        s = cyc_n;
        e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1;
        cyc(e, 1'b1);
        e = '0; e.state = 3'd1;
        cyc(e, rb());
        exp_ill = 1'b1;
        e = '0; e.state = 3'd7;
        repeat (3) cyc(e, rb());
        lit("illegal_halt_state", int'(hst(s + 2).state), 7);
        lit("illegal_no_retire", int'(hst(s + 2).instr_retired), 0);
        reset = 1'b1; exp_ill = 1'b0;
        cyc('0, rb());
        reset = 1'b0;
`else
        run_instr(32'h0000007F, 32'd0, 32'd0, 0, 0, s);
        lit("unknown_pcwrite", int'(hst(s + 2).pc_write), 1);
        lit("unknown_pcsrc", int'(hst(s + 2).pc_src), 0);
        lit("unknown_retire", int'(hst(s + 2).instr_retired), 1);
`endif

        instr = 32'h00000013;
        s = cyc_n;
        e = '0; e.mem_req = 1'b1;
        repeat (8) cyc(e, 1'b0);
        e = '0; e.state = 3'd7; e.bus_error = 1'b1;
        repeat (4) cyc(e, rb());
        lit("timeout_pre_state", int'(hst(s + 7).state), 0);
        lit("timeout_halt_state", int'(hst(s + 8).state), 7);
        lit("timeout_bus_error", int'(hst(s + 11).bus_error), 1);
        reset = 1'b1;
        cyc('0, rb());
        reset = 1'b0;
        s = cyc_n;
        e = '0; e.mem_req = 1'b1;
        cyc(e, 1'b0);
        lit("post_reset_bus_error", int'(hst(s).bus_error), 0);
        lit("post_reset_state", int'(hst(s).state), 0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
